hazard_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage pipeline.
- Compares D-stage register reads (with Tuse) against E/M-stage destinations (with Tnew) and asserts freeze to the D pipeline register and PC, plus a flush to the E register.
- Owns the mult/div busy sequencer: on a start pulse it counts the operation latency and stalls any HI/LO-class instruction reaching D while busy.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/md_busy_timer.sv | 59 +++++
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    localparam logic [T_W-1:0]   TUSE_NONE = 2'd3;
    localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy sequencer: counts the HI/LO unit latency after each start pulse.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while already busy simply restarts the count from the new latency.
    always_comb begin
        load_val = md_is_div ? DIV_LOAD : MULT_LOAD;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = load_val;
                end
            end
            BUSY: begin
                if (md_start) begin
                    cnt_d = load_val;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    assign md_busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Define HAZ_STATS_EN to build the saturating stall-cycle counter on stall_cnt.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [T_W-1:0]   d_tuse_rs,
    input  logic [T_W-1:0]   d_tuse_rt,
    input  logic             d_is_md,
    input  logic [REG_W-1:0] e_dst,
    input  logic [T_W-1:0]   e_tnew,
    input  logic [REG_W-1:0] m_dst,
    input  logic [T_W-1:0]   m_tnew,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             freeze,
    output logic             flush_e,
    output logic             md_busy,
    output logic [31:0]      stall_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // A source with Tuse=3 is never less than any Tnew, so unread operands drop out naturally.
    always_comb begin
        stall_rs = (d_rs != REG_ZERO) &&
                   (((d_rs == e_dst) && (d_tuse_rs < e_tnew)) ||
                    ((d_rs == m_dst) && (d_tuse_rs < m_tnew)));
        stall_rt = (d_rt != REG_ZERO) &&
                   (((d_rt == e_dst) && (d_tuse_rt < e_tnew)) ||
                    ((d_rt == m_dst) && (d_tuse_rt < m_tnew)));
        stall_md = d_is_md && (md_start || md_busy);
        stall    = reset && (stall_rs || stall_rt || stall_md);
    end

    assign freeze  = stall;
    assign flush_e = stall;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of stalls, busy time and stall count.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  d_rs = '0, d_rt = '0, e_dst = '0, m_dst = '0;
    logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, e_tnew = '0, m_tnew = '0;
    logic        d_is_md = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
    logic        freeze, flush_e, md_busy;
    logic [31:0] stall_cnt;

    hazard_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_is_md   (d_is_md),
        .e_dst     (e_dst),
        .e_tnew    (e_tnew),
        .m_dst     (m_dst),
        .m_tnew    (m_tnew),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .freeze    (freeze),
        .flush_e   (flush_e),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: remaining busy cycles of the HI/LO unit and total stalled edges.
    int              busy_left  = 0;
    longint unsigned stat_model = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic bit srcStall(input logic [4:0] src, input logic [1:0] tuse);
        int dst[2];
        int tnew[2];
        dst[0]  = int'(e_dst);
        dst[1]  = int'(m_dst);
        tnew[0] = int'(e_tnew);
        tnew[1] = int'(m_tnew);
        if (src == REG_ZERO || tuse == TUSE_NONE) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (int'(src) == dst[i] && int'(tuse) < tnew[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit expectStall();
        bit md_hazard;
        md_hazard = d_is_md && (md_start || busy_left > 0);
        return reset && (srcStall(d_rs, d_tuse_rs) || srcStall(d_rt, d_tuse_rt) || md_hazard);
    endfunction

    task automatic applyStimulus(input logic [4:0] rs, input logic [1:0] tuse_rs,
                                 input logic [4:0] rt, input logic [1:0] tuse_rt,
                                 input logic is_md,
                                 input logic [4:0] edst, input logic [1:0] etnew,
                                 input logic [4:0] mdst, input logic [1:0] mtnew,
                                 input logic start, input logic is_div);
        @(negedge clk);
        d_rs = rs; d_tuse_rs = tuse_rs;
        d_rt = rt; d_tuse_rt = tuse_rt;
        d_is_md = is_md;
        e_dst = edst; e_tnew = etnew;
        m_dst = mdst; m_tnew = mtnew;
        md_start = start; md_is_div = is_div;
    endtask

    // Check the current cycle against the model, then advance the model across the clock edge.
    task automatic stepCycle(input string tag);
        bit exp;
        #1;
        exp = expectStall();
        checkOutput({tag, ":freeze"}, 32'(freeze), 32'(exp));
        checkOutput({tag, ":flush_e"}, 32'(flush_e), 32'(exp));
        checkOutput({tag, ":md_busy"}, 32'(md_busy), 32'(busy_left > 0));
        checkOutput({tag, ":stall_cnt"}, stall_cnt, 32'(stat_model));
        @(posedge clk);
        if (reset) begin
            if (STATS && exp && stat_model < 64'h0000_0000_FFFF_FFFF) stat_model++;
            if (md_start) busy_left = md_is_div ? DIV_N : MULT_N;
            else if (busy_left > 0) busy_left--;
        end
    endtask

    task automatic resetModel();
        busy_left  = 0;
        stat_model = 0;
    endtask

    initial begin
        $display("[TB] hazard_ctrl bench start (stats=%0d)", STATS);

        // Reset held low with hazard-inducing inputs: everything must read quiet.
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_dst = 5'd8; e_tnew = 2'd2; d_is_md = 1'b1; md_start = 1'b1;
        #1;
        checkOutput("rst:freeze", 32'(freeze), 32'd0);
        checkOutput("rst:flush_e", 32'(flush_e), 32'd0);
        checkOutput("rst:md_busy", 32'(md_busy), 32'd0);
        checkOutput("rst:stall_cnt", stall_cnt, 32'd0);
        stepCycle("rst_hold");
        applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        stepCycle("rst_release");

        // Load-use against E, then resolved once the producer sits in M with Tnew=1.
        applyStimulus(8, 1, 0, 3, 0, 8, 2, 0, 0, 0, 0);
        #1 checkOutput("loaduse:freeze_const", 32'(freeze), 32'd1);
        stepCycle("loaduse");
        applyStimulus(8, 1, 0, 3, 0, 0, 0, 8, 1, 0, 0);
        #1 checkOutput("loaduse_m:freeze_const", 32'(freeze), 32'd0);
        stepCycle("loaduse_m");

        // rt path and register zero.
        applyStimulus(0, 3, 12, 0, 0, 0, 0, 12, 1, 0, 0);
        #1 checkOutput("rt_m:freeze_const", 32'(freeze), 32'd1);
        stepCycle("rt_m");
        applyStimulus(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
        #1 checkOutput("zero:freeze_const", 32'(freeze), 32'd0);
        stepCycle("zero");

        // Mult latency with an HI/LO instruction parked in D.
        applyStimulus(0, 3, 0, 3, 1, 0, 0, 0, 0, 1, 0);
        #1 checkOutput("mult_c0:freeze_const", 32'(freeze), 32'd1);
        stepCycle("mult_c0");
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0);
            #1;
            checkOutput($sformatf("mult_c%0d:busy_const", c), 32'(md_busy), 32'(c <= 5));
            checkOutput($sformatf("mult_c%0d:freeze_const", c), 32'(freeze), 32'(c <= 5));
            stepCycle($sformatf("mult_c%0d", c));
        end

        // Div with a second start on its last busy cycle: busy stays high for 20 cycles.
        applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 1);
        stepCycle("div2_c0");
        for (int c = 1; c <= 21; c++) begin
            applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, (c == 10), 1);
            #1 checkOutput($sformatf("div2_c%0d:busy_const", c), 32'(md_busy), 32'(c <= 20));
            stepCycle($sformatf("div2_c%0d", c));
        end

        // Asynchronous reset in the middle of a div.
        applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 1);
        stepCycle("rstdiv_c0");
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0);
            stepCycle("rstdiv_busy");
        end
        applyStimulus(0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("rstdiv_c4:busy_before", 32'(md_busy), 32'd1);
        #1 reset = 1'b0;
        resetModel();
        #1;
        checkOutput("rstdiv:busy_async", 32'(md_busy), 32'd0);
        checkOutput("rstdiv:freeze_async", 32'(freeze), 32'd0);
        stepCycle("rstdiv_hold");
        applyStimulus(0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1 checkOutput("rstdiv_release:freeze_const", 32'(freeze), 32'd0);
        stepCycle("rstdiv_release");
        stepCycle("rstdiv_release2");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            stepCycle("rand");
        end

        // Stall counter: seven stalls from a clean reset, then saturation near the top.
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        #1 reset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(8, 1, 0, 3, 0, 8, 2, 0, 0, 0, 0);
            stepCycle("stats7");
        end
        applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("stats7:cnt_const", stall_cnt, STATS ? 32'd7 : 32'd0);
        stepCycle("stats7_idle");
`ifdef HAZ_STATS_EN
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        stat_model = 64'h0000_0000_FFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 3, 9, 0, 0, 0, 0, 9, 1, 0, 0);
            stepCycle("stats_sat");
        end
        applyStimulus(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("stats_sat:cnt_const", stall_cnt, 32'hFFFF_FFFF);
        stepCycle("stats_sat_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
